// File: rtl/instr_line_controller_pkg.sv
// Shared types and ASCII constants for the instruction-line path
// (keyboard decoder, line controller, text display).
package instr_ctrl_pkg;

   typedef enum logic [1:0] {
      StEdit   = 2'd0,
      StCommit = 2'd1,
      StClear  = 2'd2
   } state_e;

   localparam int unsigned SPACE_CHAR_DEFAULT = 32;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0a;
   localparam logic [7:0] ASCII_CR    = 8'h0d;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_DEL   = 8'h7f;

endpackage

// File: rtl/instr_line_controller_if.sv
// Committed-line handshake between the line controller (master) and the
// downstream instruction consumer (slave).
interface instr_line_controller_if #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned CHAR_W  = 8
);
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   logic                      line_valid;
   logic                      line_ready;
   logic [MAX_LEN*CHAR_W-1:0] line_data;
   logic [LEN_W-1:0]          line_len;

   modport master (
      output line_valid,
      output line_data,
      output line_len,
      input  line_ready
   );

   modport slave (
      input  line_valid,
      input  line_data,
      input  line_len,
      output line_ready
   );
endinterface

// File: rtl/instr_line_controller.sv
// Single-line editor: collects key/backspace/enter pulses into a buffer, commits the
// line over a valid/ready handshake, echoes every buffer change and wipes it afterwards.
module instr_line_controller
   import instr_ctrl_pkg::*;
#(
   parameter int unsigned MAX_LEN    = 32,
   parameter int unsigned CHAR_W     = 8,
   parameter int unsigned SPACE_CHAR = SPACE_CHAR_DEFAULT,
   parameter bit          DROP_EMPTY = 1'b1
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       key_pressed,
   input  logic                       enter_pressed,
   input  logic                       bksp_pressed,
   input  logic [CHAR_W-1:0]          character,
   instr_line_controller_if.master    line,
   output logic                       echo_we,
   output logic [$clog2(MAX_LEN)-1:0] echo_col,
   output logic [CHAR_W-1:0]          echo_char,
   output logic                       busy,
   output logic                       overflow,
   output logic [7:0]                 drop_count
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned COL_W = $clog2(MAX_LEN);
   localparam logic [CHAR_W-1:0] SPACE    = CHAR_W'(SPACE_CHAR);
   localparam logic [LEN_W-1:0]  FULL     = LEN_W'(MAX_LEN);
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAX_LEN - 1);

   state_e            state_q, state_d;
   logic [CHAR_W-1:0] line_buf_q [MAX_LEN];
   logic [CHAR_W-1:0] line_buf_d [MAX_LEN];
   logic [LEN_W-1:0]  len_q, len_d;
   logic [COL_W-1:0]  idx_q, idx_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        drop_q, drop_d;
   logic              echo_we_q, echo_we_d;
   logic [COL_W-1:0]  echo_col_q, echo_col_d;
   logic [CHAR_W-1:0] echo_char_q, echo_char_d;
   logic              any_event;

   assign any_event = key_pressed | enter_pressed | bksp_pressed;

   always_comb begin
      state_d     = state_q;
      line_buf_d  = line_buf_q;
      len_d       = len_q;
      idx_d       = idx_q;
      valid_d     = valid_q;
      ovf_d       = ovf_q;
      drop_d      = drop_q;
      echo_we_d   = 1'b0;
      echo_col_d  = echo_col_q;
      echo_char_d = echo_char_q;

      // One count per busy cycle, however many pulses coincide.
      if (state_q != StEdit && any_event && drop_q != 8'hff) begin
         drop_d = drop_q + 8'd1;
      end

      unique case (state_q)
         StEdit: begin
            if (enter_pressed) begin
               if (!(len_q == '0 && DROP_EMPTY)) begin
                  state_d = StCommit;
                  valid_d = 1'b1;
               end
            end else if (bksp_pressed) begin
               if (len_q != '0) begin
                  len_d                          = len_q - 1'b1;
                  line_buf_d[COL_W'(len_d)] = SPACE;
                  echo_we_d                      = 1'b1;
                  echo_col_d                     = COL_W'(len_d);
                  echo_char_d                    = SPACE;
               end
            end else if (key_pressed) begin
               if (len_q != FULL) begin
                  line_buf_d[COL_W'(len_q)] = character;
                  len_d                          = len_q + 1'b1;
                  echo_we_d                      = 1'b1;
                  echo_col_d                     = COL_W'(len_q);
                  echo_char_d                    = character;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         StCommit: begin
            if (line.line_ready) begin
               valid_d = 1'b0;
               state_d = StClear;
               idx_d   = '0;
            end
         end
         StClear: begin
            line_buf_d[idx_q] = SPACE;
            echo_we_d         = 1'b1;
            echo_col_d        = idx_q;
            echo_char_d       = SPACE;
            if (idx_q == LAST_COL) begin
               len_d   = '0;
               ovf_d   = 1'b0;
               state_d = StEdit;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = StEdit;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= StEdit;
         for (int i = 0; i < MAX_LEN; i++) line_buf_q[i] <= SPACE;
         len_q       <= '0;
         idx_q       <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= '0;
         echo_we_q   <= 1'b0;
         echo_col_q  <= '0;
         echo_char_q <= '0;
      end else begin
         state_q     <= state_d;
         line_buf_q  <= line_buf_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         valid_q     <= valid_d;
         ovf_q       <= ovf_d;
         drop_q      <= drop_d;
         echo_we_q   <= echo_we_d;
         echo_col_q  <= echo_col_d;
         echo_char_q <= echo_char_d;
      end
   end

   always_comb begin
      line.line_data = '0;
      for (int i = 0; i < MAX_LEN; i++) line.line_data[i*CHAR_W +: CHAR_W] = line_buf_q[i];
   end

   assign line.line_valid = valid_q;
   assign line.line_len   = len_q;
   assign echo_we         = echo_we_q;
   assign echo_col        = echo_col_q;
   assign echo_char       = echo_char_q;
   assign busy            = (state_q != StEdit);
   assign overflow        = ovf_q;
   assign drop_count      = drop_q;

endmodule

// File: tb/tb_instr_line_controller.sv
// Scoreboard bench for instr_line_controller: echo writes and committed lines are
// queued as stimulus is driven and compared as the DUT produces them.
module tb_instr_line_controller;

   localparam int MAX_LEN = 32;
   localparam int CHAR_W  = 8;
   localparam logic [7:0] SP = 8'h20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       key = 1'b0, enter = 1'b0, bksp = 1'b0, enter2 = 1'b0;
   logic [7:0] ch = 8'h00;

   logic       echo_we, busy, overflow;
   logic [4:0] echo_col;
   logic [7:0] echo_char, drop_count;
   logic       echo_we2, busy2, overflow2;
   logic [4:0] echo_col2;
   logic [7:0] echo_char2, drop_count2;

   instr_line_controller_if #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) line_if ();
   instr_line_controller_if #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) line_if2 ();

   instr_line_controller #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .DROP_EMPTY(1'b1)) u_dut (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .key_pressed  (key),
      .enter_pressed(enter),
      .bksp_pressed (bksp),
      .character    (ch),
      .line         (line_if),
      .echo_we      (echo_we),
      .echo_col     (echo_col),
      .echo_char    (echo_char),
      .busy         (busy),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

   instr_line_controller #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .DROP_EMPTY(1'b0)) u_dut2 (
      .clk_in       (clk),
      .rst_in       (rst_n),
      .key_pressed  (1'b0),
      .enter_pressed(enter2),
      .bksp_pressed (1'b0),
      .character    (8'h00),
      .line         (line_if2),
      .echo_we      (echo_we2),
      .echo_col     (echo_col2),
      .echo_char    (echo_char2),
      .busy         (busy2),
      .overflow     (overflow2),
      .drop_count   (drop_count2)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic mon_en = 1'b0;

   logic [12:0]  echo_q [$];
   logic [255:0] ldata_q [$];
   logic [5:0]   llen_q [$];

   logic [7:0] mbuf [MAX_LEN];
   int         mlen;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_data();
      logic [255:0] d;
      for (int i = 0; i < MAX_LEN; i++) d[i*8 +: 8] = mbuf[i];
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < MAX_LEN; i++) mbuf[i] = SP;
      mlen = 0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (echo_we) begin
            if (echo_q.size() == 0) begin
               check("echo_unexpected", 1, 0);
            end else begin
               logic [12:0] e;
               e = echo_q.pop_front();
               check("echo_col", echo_col, e[12:8]);
               check("echo_char", echo_char, e[7:0]);
            end
         end
         if (line_if.line_valid && line_if.line_ready) begin
            if (ldata_q.size() == 0) begin
               check("line_unexpected", 1, 0);
            end else begin
               check("line_data", line_if.line_data, ldata_q.pop_front());
               check("line_len", line_if.line_len, llen_q.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [7:0] c);
      key = 1'b1;
      ch  = c;
      if (mlen < MAX_LEN) begin
         echo_q.push_back({5'(mlen), c});
         mbuf[mlen] = c;
         mlen++;
      end
      tick();
      key = 1'b0;
   endtask

   task automatic backsp();
      bksp = 1'b1;
      if (mlen > 0) begin
         mlen--;
         mbuf[mlen] = SP;
         echo_q.push_back({5'(mlen), SP});
      end
      tick();
      bksp = 1'b0;
   endtask

   task automatic enter_commit();
      ldata_q.push_back(model_data());
      llen_q.push_back(6'(mlen));
      enter = 1'b1;
      tick();
      enter = 1'b0;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !line_if.line_valid; i++) tick();
      check("valid_rise", line_if.line_valid, 1);
   endtask

   task automatic accept_and_clear();
      line_if.line_ready = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) echo_q.push_back({5'(i), SP});
      tick();
      line_if.line_ready = 1'b0;
      for (int i = 0; i < 3 * MAX_LEN && busy; i++) tick();
      check("clear_done_busy", busy, 0);
      model_reset();
      tick();
      check("clear_echo_count", echo_q.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, line_if.line_valid, 0);
      check({tag, "_len"}, line_if.line_len, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_drop"}, drop_count, 0);
      check({tag, "_echo"}, {echo_we, echo_col, echo_char}, 0);
      check({tag, "_data"}, line_if.line_data, {MAX_LEN{SP}});
   endtask

   initial begin
      line_if.line_ready  = 1'b0;
      line_if2.line_ready = 1'b0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      mon_en = 1'b1;
      check_reset_state("reset");

      // Typing "add"
      press(8'd97);
      press(8'd100);
      press(8'd100);
      tick();
      check("add_len", line_if.line_len, 3);
      check("add_data", line_if.line_data, model_data());

      // Backspace down to empty, plus one extra on the empty line
      for (int i = 0; i < 3; i++) begin
         backsp();
         check("bksp_len", line_if.line_len, mlen);
      end
      backsp();
      tick();
      check("bksp_empty_len", line_if.line_len, 0);

      // Coincident key+bksp: backspace wins
      press(8'd120);
      key = 1'b1;
      ch  = 8'd121;
      backsp();
      key = 1'b0;
      tick();
      check("prio_len", line_if.line_len, 0);
      check("prio_data", line_if.line_data, model_data());

      // Fill past capacity
      for (int i = 0; i < MAX_LEN + 1; i++) press(8'(65 + i % 26));
      tick();
      check("full_len", line_if.line_len, MAX_LEN);
      check("full_ovf", overflow, 1);
      enter_commit();
      wait_valid();
      check("full_commit_len", line_if.line_len, MAX_LEN);
      accept_and_clear();
      check("after_full_ovf", overflow, 0);

      // Empty enter: dropped when DROP_EMPTY=1, committed when 0
      enter = 1'b1;
      tick();
      enter = 1'b0;
      tick();
      check("empty_no_valid", line_if.line_valid, 0);
      check("empty_no_busy", busy, 0);
      enter2 = 1'b1;
      tick();
      enter2 = 1'b0;
      check("empty2_valid", line_if2.line_valid, 1);
      check("empty2_len", line_if2.line_len, 0);
      line_if2.line_ready = 1'b1;
      tick();
      line_if2.line_ready = 1'b0;
      for (int i = 0; i < 3 * MAX_LEN && busy2; i++) tick();
      check("empty2_idle", busy2, 0);

      // Commit "add", stall the consumer while keys arrive
      press(8'd97);
      press(8'd100);
      press(8'd100);
      enter_commit();
      wait_valid();
      for (int i = 0; i < 10; i++) begin
         key = (i % 3 == 0) && (i < 9);
         ch  = 8'd122;
         tick();
         key = 1'b0;
         check("stall_data", line_if.line_data, model_data());
         check("stall_valid", line_if.line_valid, 1);
      end
      check("drop_count", drop_count, 3);
      accept_and_clear();
      check("post_len", line_if.line_len, 0);
      check("post_ovf", overflow, 0);

      // Reset while wiping, five columns into the clear
      press(8'd113);
      enter_commit();
      wait_valid();
      line_if.line_ready = 1'b1;
      for (int i = 0; i < 5; i++) echo_q.push_back({5'(i), SP});
      tick();
      line_if.line_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      tick();
      model_reset();
      check_reset_state("midclear");
      rst_n = 1'b1;
      tick();
      tick();
      check("echo_pending", echo_q.size(), 0);
      check("line_pending", ldata_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
